// File: rtl/cnn_frame_if.sv
// Pixel stream toward the CNN core and the class result coming back.
interface cnn_frame_if #(
  parameter int PIX_W   = 8,
  parameter int CLASS_W = 4,
  parameter int SCORE_W = 32
);
  logic                      out_valid;
  logic [PIX_W-1:0]          out_data;
  logic                      res_valid;
  logic [CLASS_W-1:0]        res_class;
  logic signed [SCORE_W-1:0] res_value;

  modport master (
    output out_valid, out_data,
    input  res_valid, res_class, res_value
  );

  modport slave (
    input  out_valid, out_data,
    output res_valid, res_class, res_value
  );
endinterface

// File: rtl/cnn_frame_driver.sv
// Frame replay source and result catcher for the CNN core.
// Optional FRAME_CHECKSUM_EN adds frame_sum, a 16-bit sum of sent pixels.
module cnn_frame_driver #(
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28,
  parameter int PIX_W       = 8,
  parameter int FLUSH_LEN   = 100,
  parameter int TIMEOUT_CYC = 500000,
  parameter int CLASS_W     = 4,
  parameter int SCORE_W     = 32,
  localparam int N          = IMG_W * IMG_H,
  localparam int AW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pix_wr_en,
  input  logic [AW-1:0]             pix_wr_addr,
  input  logic [PIX_W-1:0]          pix_wr_data,
  input  logic [15:0]               gap_cycles,
  input  logic                      start,
  cnn_frame_if.master               io,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [CLASS_W-1:0]        cap_class,
  output logic signed [SCORE_W-1:0] cap_value
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]               frame_sum
`endif
);

  localparam int FW = $clog2(FLUSH_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [PIX_W-1:0] ram [N];
  logic [PIX_W-1:0] ram_q;

  logic [2:0]       state;
  logic [AW-1:0]    addr;
  logic [15:0]      gap_q;
  logic [15:0]      gap_cnt;
  logic [FW-1:0]    fl_cnt;
  logic [31:0]      to_cnt;
  logic             captured;
  logic             s1_vld;
  logic             s1_flush;
  logic             ov_q;
  logic [PIX_W-1:0] od_q;

  logic cap_now;
  logic to_hit;
  logic last_pix;

  assign io.out_valid = ov_q;
  assign io.out_data  = od_q;

  assign cap_now  = busy & ~captured & io.res_valid;
  assign to_hit   = busy & ~captured & ~cap_now &
                    (to_cnt == 32'(TIMEOUT_CYC - 1));
  assign last_pix = (addr == AW'(N - 1));

  // Frame store: not reset, frozen while a run is active.
  always_ff @(posedge clk) begin
    if (pix_wr_en && !busy)
      ram[pix_wr_addr] <= pix_wr_data;
    ram_q <= ram[addr];
  end

  // Stage 1 (s1_*) pairs with ram_q; stage 2 drives the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      fl_cnt    <= '0;
      to_cnt    <= '0;
      captured  <= 1'b0;
      s1_vld    <= 1'b0;
      s1_flush  <= 1'b0;
      ov_q      <= 1'b0;
      od_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cap_class <= '0;
      cap_value <= '0;
    end else begin
      done     <= 1'b0;
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      ov_q     <= s1_vld;
      od_q     <= (s1_vld && !s1_flush) ? ram_q : '0;
      if (busy)
        to_cnt <= to_cnt + 32'd1;
      if (cap_now) begin
        captured  <= 1'b1;
        cap_class <= io.res_class;
        cap_value <= io.res_value;
      end
      if (to_hit) begin
        state   <= S_DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        timeout <= 1'b1;
        ov_q    <= 1'b0;
        od_q    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_SEND;
              busy      <= 1'b1;
              gap_q     <= gap_cycles;
              addr      <= '0;
              to_cnt    <= '0;
              captured  <= 1'b0;
              timeout   <= 1'b0;
              cap_class <= '0;
              cap_value <= '0;
            end
          end
          S_SEND: begin
            s1_vld  <= 1'b1;
            gap_cnt <= gap_q;
            if (gap_q != 16'd0) begin
              state <= S_GAP;
            end else if (last_pix) begin
              state  <= S_FLUSH;
              fl_cnt <= '0;
            end else begin
              addr <= addr + AW'(1);
            end
          end
          S_GAP: begin
            if (gap_cnt != 16'd1) begin
              gap_cnt <= gap_cnt - 16'd1;
            end else if (last_pix) begin
              state  <= S_FLUSH;
              fl_cnt <= '0;
            end else begin
              state <= S_SEND;
              addr  <= addr + AW'(1);
            end
          end
          S_FLUSH: begin
            s1_vld   <= 1'b1;
            s1_flush <= 1'b1;
            if (fl_cnt == FW'(FLUSH_LEN - 1))
              state <= S_WAIT;
            else
              fl_cnt <= fl_cnt + FW'(1);
          end
          // Finish only once the last flush strobe has left the pipe.
          S_WAIT: begin
            if ((captured || cap_now) && !s1_vld) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_sum <= '0;
    else if (state == S_IDLE && start)
      frame_sum <= '0;
    else if (s1_vld && !s1_flush)
      frame_sum <= frame_sum + 16'(ram_q);
  end
`endif

endmodule

// File: tb/tb_cnn_frame_driver.sv
// Bench for cnn_frame_driver: random frames, gaps and result timing
// compared against a per-cycle stream model built from frame rules.
module tb_cnn_frame_driver;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int N    = W * H;
  localparam int F    = 3;
  localparam int TO   = 200;
  localparam int MAXC = 212;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_wr_en = 1'b0;
  logic [2:0]  pix_wr_addr = '0;
  logic [7:0]  pix_wr_data = '0;
  logic [15:0] gap_cycles = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [3:0]  cap_class;
  logic signed [31:0] cap_value;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif

  always #5 clk = ~clk;

  cnn_frame_if #(.PIX_W(8), .CLASS_W(4), .SCORE_W(32)) ifc ();

  cnn_frame_driver #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .FLUSH_LEN(F),
    .TIMEOUT_CYC(TO), .CLASS_W(4), .SCORE_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pix_wr_en(pix_wr_en),
    .pix_wr_addr(pix_wr_addr),
    .pix_wr_data(pix_wr_data),
    .gap_cycles(gap_cycles),
    .start(start),
    .io(ifc),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cap_class(cap_class),
    .cap_value(cap_value)
`ifdef FRAME_CHECKSUM_EN
    ,
    .frame_sum(frame_sum)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [N];
  int         r_cyc [2];
  logic [3:0] r_cls [2];
  int         r_val [2];

  logic       rec_v [MAXC];
  logic [7:0] rec_d [MAXC];
  logic       rec_b [MAXC];
  logic       rec_dn [MAXC];
  int         got_done;
  logic       got_to;
  logic [3:0] got_cls;
  int         got_val;
  logic [15:0] got_sum;

  logic       ev [MAXC];
  logic [7:0] ed [MAXC];
  int         exp_done;
  logic       exp_to;
  logic [3:0] exp_cls;
  int         exp_val;

  task automatic load_ram();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      pix_wr_en = 1'b1;
      pix_wr_addr = 3'(i);
      pix_wr_data = mem[i];
    end
    @(negedge clk);
    pix_wr_en = 1'b0;
  endtask

  task automatic set_res(input int a, input logic [3:0] ca, input int va,
                         input int b, input logic [3:0] cb, input int vb);
    r_cyc[0] = a; r_cls[0] = ca; r_val[0] = va;
    r_cyc[1] = b; r_cls[1] = cb; r_val[1] = vb;
  endtask

  // Index c = cycle after the c-th clock edge following the start edge.
  task automatic build_model(input int g);
    int t_end;
    int cap_at;
    int who;
    for (int c = 0; c < MAXC; c++) begin
      ev[c] = 1'b0;
      ed[c] = 8'h00;
    end
    for (int i = 0; i < N; i++) begin
      ev[2 + i * (1 + g)] = 1'b1;
      ed[2 + i * (1 + g)] = mem[i];
    end
    for (int j = 0; j < F; j++)
      ev[2 + N * (1 + g) + j] = 1'b1;
    t_end = 2 + N * (1 + g) + F;
    cap_at = -1;
    who = 0;
    for (int r = 0; r < 2; r++)
      if (r_cyc[r] >= 1 && r_cyc[r] <= TO && (cap_at < 0 || r_cyc[r] < cap_at)) begin
        cap_at = r_cyc[r];
        who = r;
      end
    if (cap_at >= 0) begin
      exp_done = (cap_at > t_end) ? cap_at : t_end;
      exp_to = 1'b0;
      exp_cls = r_cls[who];
      exp_val = r_val[who];
    end else begin
      exp_done = TO;
      exp_to = 1'b1;
      exp_cls = 4'd0;
      exp_val = 0;
      for (int c = TO; c < MAXC; c++)
        ev[c] = 1'b0;
    end
  endtask

  task automatic run_dut(input int g, input int poke, input bit ws, input logic [7:0] wsd);
    for (int c = 0; c < MAXC; c++) begin
      rec_v[c] = 1'bx;
      rec_d[c] = 8'hxx;
      rec_b[c] = 1'bx;
      rec_dn[c] = 1'bx;
    end
    @(negedge clk);
    gap_cycles = 16'(g);
    start = 1'b1;
    if (ws) begin
      pix_wr_en = 1'b1;
      pix_wr_addr = 3'd0;
      pix_wr_data = wsd;
    end
    @(negedge clk);
    start = 1'b0;
    pix_wr_en = 1'b0;
    got_done = -1;
    rec_v[0] = ifc.out_valid; rec_d[0] = ifc.out_data;
    rec_b[0] = busy; rec_dn[0] = done;
    for (int c = 1; c < MAXC; c++) begin
      ifc.res_valid = 1'b0;
      for (int r = 0; r < 2; r++)
        if (c == r_cyc[r]) begin
          ifc.res_valid = 1'b1;
          ifc.res_class = r_cls[r];
          ifc.res_value = r_val[r];
        end
      start = (c == poke);
      pix_wr_en = (c == poke);
      pix_wr_addr = 3'd7;
      pix_wr_data = 8'hAA;
      @(negedge clk);
      rec_v[c] = ifc.out_valid; rec_d[c] = ifc.out_data;
      rec_b[c] = busy; rec_dn[c] = done;
      if (got_done < 0 && done === 1'b1) got_done = c;
      if (got_done >= 0 && c == got_done + 1) break;
    end
    ifc.res_valid = 1'b0;
    start = 1'b0;
    pix_wr_en = 1'b0;
    got_to = timeout;
    got_cls = cap_class;
    got_val = cap_value;
`ifdef FRAME_CHECKSUM_EN
    got_sum = frame_sum;
`else
    got_sum = 16'h0;
`endif
  endtask

  task automatic test_reset();
    ifc.res_valid = 1'b0;
    ifc.res_class = '0;
    ifc.res_value = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifc.out_valid, ifc.out_data, busy, done, timeout, cap_class, cap_value} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h b=%b dn=%b to=%b c=%h val=%0d exp all 0",
               ifc.out_valid, ifc.out_data, busy, done, timeout, cap_class, cap_value);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.out_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got v=%b b=%b dn=%b exp 000", ifc.out_valid, busy, done);
    end
  endtask

  task automatic test_gap2();
    for (int i = 0; i < N; i++) mem[i] = 8'(i + 1);
    load_ram();
    set_res(32, 4'($urandom), int'($urandom), -1, 4'd0, 0);
    run_dut(2, -1, 1'b0, 8'h00);
    build_model(2);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL gap2_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
    checks++;
    if (rec_dn[exp_done + 1] !== 1'b0 || got_done !== exp_done) begin
      failures++;
      $display("FAIL gap2_done got cyc=%0d exp cyc=%0d", got_done, exp_done);
    end
    checks++;
    if (got_to !== exp_to || got_cls !== exp_cls || got_val !== exp_val) begin
      failures++;
      $display("FAIL gap2_result got to=%b c=%0d v=%0d exp to=%b c=%0d v=%0d",
               got_to, got_cls, got_val, exp_to, exp_cls, exp_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] nd;
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    load_ram();
    nd = 8'($urandom);
    mem[0] = nd;
    set_res(4, 4'($urandom), int'($urandom), -1, 4'd0, 0);
    run_dut(0, -1, 1'b1, nd);
    build_model(0);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL b2b_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
    checks++;
    if (got_to !== exp_to || got_cls !== exp_cls || got_val !== exp_val) begin
      failures++;
      $display("FAIL b2b_result got to=%b c=%0d v=%0d exp to=%b c=%0d v=%0d",
               got_to, got_cls, got_val, exp_to, exp_cls, exp_val);
    end
  endtask

  task automatic test_early_result();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    load_ram();
    set_res(7, 4'd7, -42, 11, 4'd2, int'($urandom));
    run_dut(1, -1, 1'b0, 8'h00);
    build_model(1);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL early_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
    checks++;
    if (got_to !== 1'b0 || got_cls !== 4'd7 || got_val !== -42) begin
      failures++;
      $display("FAIL early_result got to=%b c=%0d v=%0d exp to=0 c=7 v=-42",
               got_to, got_cls, got_val);
    end
  endtask

  task automatic test_timeout();
    int g;
    g = int'($urandom_range(0, 3));
    set_res(-1, 4'd0, 0, -1, 4'd0, 0);
    run_dut(g, -1, 1'b0, 8'h00);
    build_model(g);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL timeout_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
    checks++;
    if (got_done !== TO || got_to !== 1'b1 || got_cls !== 4'd0 || got_val !== 0) begin
      failures++;
      $display("FAIL timeout_result got cyc=%0d to=%b c=%0d v=%0d exp cyc=%0d to=1 c=0 v=0",
               got_done, got_to, got_cls, got_val, TO);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    load_ram();
    @(negedge clk);
    gap_cycles = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== mem[3]) begin
      failures++;
      $display("FAIL rst_pix4 got v=%b d=%h exp v=1 d=%h", ifc.out_valid, ifc.out_data, mem[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ifc.out_valid, ifc.out_data, busy, done, timeout, cap_class, cap_value} !== '0) begin
      failures++;
      $display("FAIL rst_async got v=%b d=%h b=%b dn=%b to=%b exp all 0",
               ifc.out_valid, ifc.out_data, busy, done, timeout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_done got dn=%b exp 0", done);
      end
    end
    rst_n = 1'b1;
    set_res(16, 4'($urandom), int'($urandom), -1, 4'd0, 0);
    run_dut(0, -1, 1'b0, 8'h00);
    build_model(0);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL rst_replay c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
  endtask

  task automatic test_busy_ignored();
    logic [15:0] sum;
    sum = 16'h0;
    for (int i = 0; i < N; i++) begin
      mem[i] = 8'hFF;
      sum = sum + 16'(mem[i]);
    end
    load_ram();
    set_res(int'($urandom_range(1, 25)), 4'($urandom), int'($urandom), -1, 4'd0, 0);
    run_dut(1, 5, 1'b0, 8'h00);
    build_model(1);
    for (int c = 0; c <= exp_done; c++) begin
      checks++;
      if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
          rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
        failures++;
        $display("FAIL busy_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", c,
                 rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
      end
    end
`ifdef FRAME_CHECKSUM_EN
    checks++;
    if (got_sum !== 16'h07F8 || got_sum !== sum) begin
      failures++;
      $display("FAIL checksum got %h exp %h", got_sum, sum);
    end
`else
    if (got_sum !== 16'h0 && sum === 16'h0) $display("note: sum %h", got_sum);
`endif
  endtask

  task automatic test_random();
    int g;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      load_ram();
      g = int'($urandom_range(0, 4));
      set_res(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 70)),
              4'($urandom), int'($urandom),
              int'($urandom_range(1, 70)), 4'($urandom), int'($urandom));
      run_dut(g, -1, 1'b0, 8'h00);
      build_model(g);
      for (int c = 0; c <= exp_done; c++) begin
        checks++;
        if (rec_v[c] !== ev[c] || (ev[c] && rec_d[c] !== ed[c]) ||
            rec_b[c] !== (c < exp_done) || rec_dn[c] !== (c == exp_done)) begin
          failures++;
          $display("FAIL rand%0d_stream c=%0d got v=%b d=%h b=%b dn=%b exp v=%b d=%h", it, c,
                   rec_v[c], rec_d[c], rec_b[c], rec_dn[c], ev[c], ed[c]);
        end
      end
      checks++;
      if (got_to !== exp_to || got_cls !== exp_cls || got_val !== exp_val) begin
        failures++;
        $display("FAIL rand%0d_result got to=%b c=%0d v=%0d exp to=%b c=%0d v=%0d", it,
                 got_to, got_cls, got_val, exp_to, exp_cls, exp_val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gap2();
    test_back_to_back();
    test_early_result();
    test_timeout();
    test_reset_mid_run();
    test_busy_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
